// File: rtl/temporizador_regressivo_param.sv
// -----------------------------------------------------------------------------
// temporizador_regressivo_param
//
// Parametrised countdown timer. Divides CLOCK down to tenth-of-second ticks
// and counts a BCD display (M:SS,d) down from a preset to 0:00,0, with
// pause/resume, whole-second penalties, defuse, a low-time warning and a
// hard stop at zero.
//
// Parameters:
//   CLK_DIV      CLOCK cycles per tenth of a second (>= 2)
//   PRESET_MIN   minutes loaded by START (0..9)
//   PRESET_SEC   seconds loaded by START (0..59); preset must be nonzero
//   WARN_SEC     WARNING while remaining whole seconds < WARN_SEC (1..59)
//   PENALTY_SEC  seconds removed per PENALTY pulse (1..59)
//
// Ports:
//   CLOCK, RESET_N          clock, asynchronous active-low reset
//   START                   load preset and run (any state)
//   PAUSE / RESUME          RUN -> PAUSED / PAUSED -> RUN
//   PENALTY                 subtract PENALTY_SEC (RUN or PAUSED)
//   DEFUSE                  freeze display, end round (RUN or PAUSED)
//   DECIMOS                 tenths digit (BCD)
//   SEGUNDOS_UNIDADE        seconds units digit (BCD)
//   SEGUNDOS_DEZENAS        seconds tens digit (0..5)
//   MINUTOS                 minutes digit (BCD)
//   RUNNING                 state is RUN
//   WARNING                 low remaining time while RUN or PAUSED
//   TEMPO_ACABOU            state is EXPIRED
//   DESARMADA               state is DEFUSED
//   TICK                    a tenth decrement is applied on the next edge
// -----------------------------------------------------------------------------
module temporizador_regressivo_param #(
    parameter int CLK_DIV     = 100,
    parameter int PRESET_MIN  = 2,
    parameter int PRESET_SEC  = 0,
    parameter int WARN_SEC    = 10,
    parameter int PENALTY_SEC = 10
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       RESUME,
    input  logic       PENALTY,
    input  logic       DEFUSE,
    output logic [3:0] DECIMOS,
    output logic [3:0] SEGUNDOS_UNIDADE,
    output logic [3:0] SEGUNDOS_DEZENAS,
    output logic [3:0] MINUTOS,
    output logic       RUNNING,
    output logic       WARNING,
    output logic       TEMPO_ACABOU,
    output logic       DESARMADA,
    output logic       TICK
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_EXPIRED,
        ST_DEFUSED
    } state_e;

    typedef struct packed {
        logic [3:0] mins;
        logic [3:0] tens;
        logic [3:0] units;
        logic [3:0] tenths;
    } time_t;

    localparam time_t PRESET_TIME = '{
        mins:   4'(PRESET_MIN),
        tens:   4'(PRESET_SEC / 10),
        units:  4'(PRESET_SEC % 10),
        tenths: 4'd0
    };

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    time_t          time_q, time_d;

    logic           tick;
    logic           active;
    logic           pen_ok;
    time_t          after_tick;
    time_t          after_pen;
    logic [9:0]     whole_secs;
    logic [9:0]     pen_rem;
    logic [9:0]     pen_s60;
    logic [6:0]     disp_secs;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        after_tick = time_q;
        after_pen  = time_q;
        whole_secs = '0;
        pen_rem    = '0;
        pen_s60    = '0;

        tick   = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
        active = (state_q == ST_RUN) || (state_q == ST_PAUSED);
        pen_ok = PENALTY && active;

        // One-tenth BCD decrement with 9/9/5 borrow chain. Zero is never held
        // in RUN, but the guard keeps the digits legal regardless.
        if (tick && (time_q != '0)) begin
            if (time_q.tenths != 4'd0) begin
                after_tick.tenths = time_q.tenths - 4'd1;
            end else begin
                after_tick.tenths = 4'd9;
                if (time_q.units != 4'd0) begin
                    after_tick.units = time_q.units - 4'd1;
                end else begin
                    after_tick.units = 4'd9;
                    if (time_q.tens != 4'd0) begin
                        after_tick.tens = time_q.tens - 4'd1;
                    end else begin
                        after_tick.tens = 4'd5;
                        after_tick.mins = time_q.mins - 4'd1;
                    end
                end
            end
        end

        // Penalty works on whole seconds; tenths are carried through.
        // If fewer whole seconds remain than the penalty, the total time is
        // below the penalty and the result saturates at 0:00,0.
        after_pen  = after_tick;
        whole_secs = 10'(after_tick.mins) * 10'd60
                   + 10'(after_tick.tens) * 10'd10
                   + 10'(after_tick.units);
        if (pen_ok) begin
            if (whole_secs < 10'(PENALTY_SEC)) begin
                after_pen = '0;
            end else begin
                pen_rem         = whole_secs - 10'(PENALTY_SEC);
                pen_s60         = pen_rem % 10'd60;
                after_pen.mins  = 4'(pen_rem / 10'd60);
                after_pen.tens  = 4'(pen_s60 / 10'd10);
                after_pen.units = 4'(pen_s60 % 10'd10);
            end
        end

        if (START) begin
            state_d = ST_RUN;
            time_d  = PRESET_TIME;
            presc_d = '0;
        end else if (DEFUSE && active) begin
            // Display and prescaler freeze; same-edge tick/penalty dropped.
            state_d = ST_DEFUSED;
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            time_d = after_pen;
            if ((tick || pen_ok) && (after_pen == '0)) begin
                state_d = ST_EXPIRED;
            end else if (PAUSE && (state_q == ST_RUN)) begin
                state_d = ST_PAUSED;
            end else if (RESUME && (state_q == ST_PAUSED)) begin
                state_d = ST_RUN;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            time_q  <= PRESET_TIME;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            time_q  <= time_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: direct decode of registered state
    // -------------------------------------------------------------------------
    assign disp_secs = 7'(time_q.tens) * 7'd10 + 7'(time_q.units);

    assign DECIMOS          = time_q.tenths;
    assign SEGUNDOS_UNIDADE = time_q.units;
    assign SEGUNDOS_DEZENAS = time_q.tens;
    assign MINUTOS          = time_q.mins;
    assign RUNNING          = (state_q == ST_RUN);
    assign TEMPO_ACABOU     = (state_q == ST_EXPIRED);
    assign DESARMADA        = (state_q == ST_DEFUSED);
    assign TICK             = tick;
    assign WARNING          = ((state_q == ST_RUN) || (state_q == ST_PAUSED))
                            && (time_q.mins == 4'd0)
                            && (disp_secs < 7'(WARN_SEC));

endmodule

// File: tb/tb_temporizador_regressivo_param.sv
// -----------------------------------------------------------------------------
// tb_temporizador_regressivo_param
//
// Drives the countdown timer with directed scenarios followed by random pulse
// traffic. Expected outputs come from a model that keeps remaining time as a
// plain count of tenths and derives the displayed digits with / and %.
// -----------------------------------------------------------------------------
module tb_temporizador_regressivo_param;

    localparam int CLK_DIV  = 4;
    localparam int P_MIN    = 1;
    localparam int P_SEC    = 27;
    localparam int WARN     = 10;
    localparam int PEN      = 10;
    localparam int PRESET_T = (P_MIN * 60 + P_SEC) * 10;

    localparam int S_IDLE    = 0;
    localparam int S_RUN     = 1;
    localparam int S_PAUSED  = 2;
    localparam int S_EXPIRED = 3;
    localparam int S_DEFUSED = 4;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       START, PAUSE, RESUME, PENALTY, DEFUSE;
    logic [3:0] DECIMOS, SEGUNDOS_UNIDADE, SEGUNDOS_DEZENAS, MINUTOS;
    logic       RUNNING, WARNING, TEMPO_ACABOU, DESARMADA, TICK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state;
    int m_rem;     // remaining time in tenths of a second
    int m_presc;   // cycles spent in RUN since the last tenth

    temporizador_regressivo_param #(
        .CLK_DIV    (CLK_DIV),
        .PRESET_MIN (P_MIN),
        .PRESET_SEC (P_SEC),
        .WARN_SEC   (WARN),
        .PENALTY_SEC(PEN)
    ) dut (
        .CLOCK           (CLOCK),
        .RESET_N         (RESET_N),
        .START           (START),
        .PAUSE           (PAUSE),
        .RESUME          (RESUME),
        .PENALTY         (PENALTY),
        .DEFUSE          (DEFUSE),
        .DECIMOS         (DECIMOS),
        .SEGUNDOS_UNIDADE(SEGUNDOS_UNIDADE),
        .SEGUNDOS_DEZENAS(SEGUNDOS_DEZENAS),
        .MINUTOS         (MINUTOS),
        .RUNNING         (RUNNING),
        .WARNING         (WARNING),
        .TEMPO_ACABOU    (TEMPO_ACABOU),
        .DESARMADA       (DESARMADA),
        .TICK            (TICK)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_rem   = PRESET_T;
        m_presc = 0;
    endtask

    task automatic model_edge(input logic st, input logic pa, input logic re,
                              input logic pe, input logic de);
        int old;
        bit tk;
        bit pn;
        old = m_state;
        if (st) begin
            m_rem   = PRESET_T;
            m_presc = 0;
            m_state = S_RUN;
        end else if (de && (old == S_RUN || old == S_PAUSED)) begin
            m_state = S_DEFUSED;
        end else begin
            tk = (old == S_RUN) && (m_presc == CLK_DIV - 1);
            pn = pe && (old == S_RUN || old == S_PAUSED);
            if (old == S_RUN) m_presc = tk ? 0 : m_presc + 1;
            if (tk) m_rem = m_rem - 1;
            if (pn) m_rem = m_rem - PEN * 10;
            if (m_rem < 0) m_rem = 0;
            if ((tk || pn) && m_rem == 0) m_state = S_EXPIRED;
            else if (pa && old == S_RUN) m_state = S_PAUSED;
            else if (re && old == S_PAUSED) m_state = S_RUN;
        end
    endtask

    task automatic compare(input string tag);
        int secs;
        logic [15:0] exp_digits;
        logic [4:0]  exp_flags;
        secs = (m_rem / 10) % 60;
        exp_digits = {4'(m_rem / 600), 4'(secs / 10), 4'(secs % 10), 4'(m_rem % 10)};
        exp_flags  = {m_state == S_RUN,
                      (m_state == S_RUN || m_state == S_PAUSED) && (m_rem / 10 < WARN),
                      m_state == S_EXPIRED,
                      m_state == S_DEFUSED,
                      (m_state == S_RUN) && (m_presc == CLK_DIV - 1)};
        check({tag, ".digits"}, 32'({MINUTOS, SEGUNDOS_DEZENAS, SEGUNDOS_UNIDADE, DECIMOS}),
              32'(exp_digits));
        check({tag, ".flags(run,warn,exp,def,tick)"},
              32'({RUNNING, WARNING, TEMPO_ACABOU, DESARMADA, TICK}), 32'(exp_flags));
    endtask

    // One clock edge with the given pulses; outputs checked 1 time unit later.
    task automatic step(input string tag, input logic st, input logic pa, input logic re,
                        input logic pe, input logic de);
        START = st; PAUSE = pa; RESUME = re; PENALTY = pe; DEFUSE = de;
        @(posedge CLOCK);
        model_edge(st, pa, re, pe, de);
        #1;
        compare(tag);
        START = 1'b0; PAUSE = 1'b0; RESUME = 1'b0; PENALTY = 1'b0; DEFUSE = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (m_rem > target && m_state == S_RUN && n < 6000) begin
            step("count", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 6000) begin
            errors++;
            $display("FAIL run_until: step budget exhausted before %0d tenths", target);
        end
    endtask

    initial begin
        int n;
        RESET_N = 1'b0;
        START = 1'b0; PAUSE = 1'b0; RESUME = 1'b0; PENALTY = 1'b0; DEFUSE = 1'b0;
        model_reset();
        repeat (2) @(negedge CLOCK);
        compare("reset");
        RESET_N = 1'b1;
        @(negedge CLOCK);
        compare("idle_after_reset");
        idle(3);

        // Basic countdown through the 1:00,0 -> 0:59,9 full borrow
        step("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1101);

        // Pause for 50 cycles with the prescaler mid-count, then resume
        step("pause", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(50);
        step("resume", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);

        // Penalty in RUN at 0:25,3 -> 0:15,3
        run_until(253);
        step("penalty_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Penalty while paused at 0:07,8 saturates to 0:00,0 and expires
        run_until(78);
        step("pause2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step("penalty_paused_sat", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Restart from EXPIRED; penalty coinciding with tick at 0:30,0 -> 0:19,9
        step("start_from_expired", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(m_state == S_RUN && m_rem == 300 && m_presc == CLK_DIV - 1) && n < 6000) begin
            step("count", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 6000) begin
            errors++;
            $display("FAIL align: 0:30,0 tick not reached");
        end
        step("penalty_with_tick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Warning zone, then defuse at 0:04,2; later pulses are ignored
        run_until(42);
        step("defuse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("penalty_defused", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        step("resume_defused", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("defuse_defused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Restart during RUN at 1:12,5
        step("start_from_defused", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until(725);
        step("restart_in_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Asynchronous reset between edges
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        compare("async_reset");
        #2;
        RESET_N = 1'b1;
        idle(2);

        // START and DEFUSE on the same edge while running
        step("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        step("start_and_defuse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Natural expiry from the full preset; zero must hold
        run_until(0);
        idle(10);
        step("penalty_expired", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("defuse_expired", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random pulse traffic
        step("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic st, pa, re, pe, de;
            if (m_state == S_RUN || m_state == S_PAUSED)
                st = ($urandom % 400) == 0;
            else
                st = ($urandom % 15) == 0;
            pa = ($urandom % 25) == 0;
            re = ($urandom % 15) == 0;
            pe = ($urandom % 60) == 0;
            de = ($urandom % 250) == 0;
            step("random", st, pa, re, pe, de);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temporizador_regressivo_param.md
Name: temporizador_regressivo_param

Overview:
- Parametrised successor to the fixed 2:00,0 countdown of the bomb-clock design.
- Divides the fast system CLOCK down to tenth-of-second ticks and counts down from a configurable preset to 0:00,0.
- Adds pause/resume, time penalties, defuse, a low-time warning and a true zero stop.
- Sits between the debounced input/game-logic layer and the 7-segment BCD decoders.

Parameters:
- CLK_DIV, 100: CLOCK cycles per tenth of a second. Must be ≥2.
- PRESET_MIN, 2: minutes loaded by START. Range 0..9.
- PRESET_SEC, 0: seconds loaded by START. Range 0..59. Total preset must be nonzero.
- WARN_SEC, 10: WARNING is asserted while remaining time is below this many seconds. Range 1..59.
- PENALTY_SEC, 10: seconds removed per PENALTY pulse. Range 1..59.

Ports:
- CLOCK, in, 1: system clock, 1 kHz nominal.
- RESET_N, in, 1: asynchronous, active-low reset.
- START, in, 1: one-cycle pulse. Loads the preset and runs. Accepted in any state.
- PAUSE, in, 1: one-cycle pulse. RUN → PAUSED.
- RESUME, in, 1: one-cycle pulse. PAUSED → RUN.
- PENALTY, in, 1: one-cycle pulse. Subtracts PENALTY_SEC.
- DEFUSE, in, 1: one-cycle pulse. Freezes the display and ends the round.
- DECIMOS, out, 4: tenths digit, BCD 0..9.
- SEGUNDOS_UNIDADE, out, 4: seconds units digit, BCD 0..9.
- SEGUNDOS_DEZENAS, out, 4: seconds tens digit, BCD 0..5.
- MINUTOS, out, 4: minutes digit, BCD 0..9.
- RUNNING, out, 1: high in RUN.
- WARNING, out, 1: low-time flag.
- TEMPO_ACABOU, out, 1: high in EXPIRED.
- DESARMADA, out, 1: high in DEFUSED.
- TICK, out, 1: high for the one cycle in which a tenth decrement is applied.

Behaviour:
- **States:** IDLE, RUN, PAUSED, EXPIRED, DEFUSED.
- **Reset (RESET_N=0, asynchronous):**
  - State = IDLE.
  - Digits = preset: MINUTOS = PRESET_MIN, SEGUNDOS_* = PRESET_SEC split into tens/units, DECIMOS = 0.
  - Prescaler = 0.
  - All flag outputs = 0.
  - Reset mid-count discards everything.
- **Priority per edge:** START > DEFUSE > (tenth tick, PENALTY) > PAUSE/RESUME.
- **START:**
  - Reload the preset and clear the prescaler.
  - Next state = RUN, including from EXPIRED, DEFUSED and RUN itself (restart).
- **Prescaler:**
  - Increments only in RUN.
  - At CLK_DIV-1, the same edge sets it to 0 and decrements by one tenth, with BCD borrow 9/9/5 across DECIMOS → SEGUNDOS_UNIDADE → SEGUNDOS_DEZENAS → MINUTOS.
  - TICK = (state == RUN) && (prescaler == CLK_DIV-1).
  - First decrement occurs exactly CLK_DIV cycles after START.
  - Held, not cleared, in PAUSED.
- **Expiry:**
  - When a decrement or penalty makes the remaining time 0:00,0, the same edge sets the digits to 0 and the state to EXPIRED.
  - Counting stops only at 0:00,0, never on MINUTOS == 0 alone.
- **PENALTY:**
  - Accepted in RUN and PAUSED; ignored elsewhere.
  - Subtracts PENALTY_SEC whole seconds; DECIMOS is unchanged.
  - If remaining < PENALTY_SEC s, saturate to 0:00,0 and enter EXPIRED. This applies even from PAUSED.
  - A tick and a penalty on the same edge combine: result = remaining − 0,1 s − PENALTY_SEC, saturating at zero.
- **PAUSE:**
  - Only in RUN; ignored elsewhere.
  - A tick on the same edge is still applied.
- **RESUME:** only in PAUSED; ignored elsewhere.
- **DEFUSE:**
  - In RUN or PAUSED: → DEFUSED, digits frozen at their current value, and any same-edge tick or penalty is discarded.
  - Ignored in IDLE and EXPIRED.
- **Terminal states:** EXPIRED and DEFUSED hold until START or reset.
- **Outputs:**
  - All outputs are registered state or a direct decode of it, with no extra latency.
  - WARNING = (RUN or PAUSED) && MINUTOS == 0 && seconds value < WARN_SEC. DECIMOS is ignored for this comparison.
  - TEMPO_ACABOU and DESARMADA are mutually exclusive.
  - Digits must never show a non-BCD value or seconds > 59.

Test Plan:
1. **Basic countdown.** CLK_DIV=4, PRESET 0:03; RESET_N low then high, START → display 0:03,0. TICK every 4 cycles; 0:02,9 appears 4 cycles after START. TEMPO_ACABOU rises on the edge producing 0:00,0 (120 cycles after START) and stays high; digits remain 0.
2. **Pause/resume and borrow.** PRESET 1:00; START, wait 4 cycles → 0:59,9 (borrow across all digits). PAUSE → display held for 50 cycles, RUNNING=0. RESUME → next decrement exactly 4 − (cycles already elapsed in prescaler) cycles later.
3. **Penalty and saturation.**
   - PENALTY at 0:25,3 → 0:15,3.
   - PENALTY at 0:07,8 while PAUSED → 0:00,0, EXPIRED.
   - PENALTY coinciding with TICK at 0:30,0 → 0:19,9.
4. **Warning and defuse.** WARN_SEC=10: WARNING rises at the 0:10,0 → 0:09,9 transition. DEFUSE at 0:04,2 → DESARMADA=1, display frozen at 0:04,2. WARNING and RUNNING drop; further PENALTY is ignored.
5. **Restart and async reset.**
   - START during RUN at 1:12,5 → reload 2:00,0 with prescaler cleared.
   - START from EXPIRED → RUN with flags cleared.
   - RESET_N low mid-cycle → outputs go to reset values immediately, without waiting for a CLOCK edge.
6. **Priority.** START and DEFUSE on the same edge → RUN with preset loaded.
